// File: rtl/ypbpr_to_rgb.sv
//==============================================================================
// Module      : ypbpr_to_rgb
// Description : 3-stage YPbPr -> RGB decoder, limited/full range, with bypass.
//               Optional clip statistics built when YPBPR_CLIP_STATS_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ypbpr_to_rgb (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic        ypbpr_en,
    input  logic        full_range,
    input  logic [23:0] din,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        csync,
    input  logic        de,
    output logic [23:0] dout,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        csync_o,
    output logic        de_o,
    output logic [15:0] clip_cnt
);

    localparam logic signed [20:0] C_LIM_Y   = 21'sd298;
    localparam logic signed [20:0] C_LIM_RV  = 21'sd409;
    localparam logic signed [20:0] C_LIM_GU  = 21'sd100;
    localparam logic signed [20:0] C_LIM_GV  = 21'sd208;
    localparam logic signed [20:0] C_LIM_BU  = 21'sd516;
    localparam logic signed [20:0] C_FULL_Y  = 21'sd256;
    localparam logic signed [20:0] C_FULL_RV = 21'sd359;
    localparam logic signed [20:0] C_FULL_GU = 21'sd88;
    localparam logic signed [20:0] C_FULL_GV = 21'sd183;
    localparam logic signed [20:0] C_FULL_BU = 21'sd454;

    // ---------------- Stage 1: offset removal ----------------
    logic signed [9:0] w_y1, w_pb1, w_pr1;
    logic signed [9:0] r_y1, r_pb1, r_pr1;
    logic              r_en1, r_full1;
    logic [23:0]       r_raw1;
    logic [3:0]        r_sync1;

    always_comb begin
        w_y1  = $signed({2'b00, din[15:8]}) - (full_range ? 10'sd0 : 10'sd16);
        w_pb1 = $signed({2'b00, din[7:0]})  - 10'sd128;
        w_pr1 = $signed({2'b00, din[23:16]}) - 10'sd128;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_y1    <= '0;
            r_pb1   <= '0;
            r_pr1   <= '0;
            r_en1   <= 1'b0;
            r_full1 <= 1'b0;
            r_raw1  <= '0;
            r_sync1 <= '0;
        end else if (ce_pix) begin
            r_y1    <= w_y1;
            r_pb1   <= w_pb1;
            r_pr1   <= w_pr1;
            r_en1   <= ypbpr_en;
            r_full1 <= full_range;
            r_raw1  <= din;
            r_sync1 <= {hsync, vsync, csync, de};
        end
    end

    // ---------------- Stage 2: matrix multiply ----------------
    logic signed [20:0] w_ye, w_pbe, w_pre;
    logic signed [20:0] w_ky, w_krv, w_kgu, w_kgv, w_kbu;
    logic signed [20:0] w_r2, w_g2, w_b2;
    logic signed [20:0] r_r2, r_g2, r_b2;
    logic               r_en2;
    logic [23:0]        r_raw2;
    logic [3:0]         r_sync2;

    always_comb begin
        w_ye  = {{11{r_y1[9]}},  r_y1};
        w_pbe = {{11{r_pb1[9]}}, r_pb1};
        w_pre = {{11{r_pr1[9]}}, r_pr1};
        w_ky  = r_full1 ? C_FULL_Y  : C_LIM_Y;
        w_krv = r_full1 ? C_FULL_RV : C_LIM_RV;
        w_kgu = r_full1 ? C_FULL_GU : C_LIM_GU;
        w_kgv = r_full1 ? C_FULL_GV : C_LIM_GV;
        w_kbu = r_full1 ? C_FULL_BU : C_LIM_BU;
        w_r2  = w_ky * w_ye + w_krv * w_pre;
        w_g2  = w_ky * w_ye - w_kgu * w_pbe - w_kgv * w_pre;
        w_b2  = w_ky * w_ye + w_kbu * w_pbe;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_r2    <= '0;
            r_g2    <= '0;
            r_b2    <= '0;
            r_en2   <= 1'b0;
            r_raw2  <= '0;
            r_sync2 <= '0;
        end else if (ce_pix) begin
            r_r2    <= w_r2;
            r_g2    <= w_g2;
            r_b2    <= w_b2;
            r_en2   <= r_en1;
            r_raw2  <= r_raw1;
            r_sync2 <= r_sync1;
        end
    end

    // ---------------- Stage 3: round, shift, clamp ----------------
    function automatic logic [7:0] clamp8(input logic signed [20:0] v);
        if (v < 0)
            return 8'd0;
        else if (v > 21'sd255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    function automatic logic is_clip(input logic signed [20:0] v);
        return (v < 0) || (v > 21'sd255);
    endfunction

    logic signed [20:0] w_r3, w_g3, w_b3;
    logic [23:0]        w_dout3;
    logic               w_clip3;
    logic               r_clip3;

    always_comb begin
        w_r3 = (r_r2 + 21'sd128) >>> 8;
        w_g3 = (r_g2 + 21'sd128) >>> 8;
        w_b3 = (r_b2 + 21'sd128) >>> 8;
        if (r_en2) begin
            w_dout3 = {clamp8(w_r3), clamp8(w_g3), clamp8(w_b3)};
            w_clip3 = is_clip(w_r3) | is_clip(w_g3) | is_clip(w_b3);
        end else begin
            w_dout3 = r_raw2;
            w_clip3 = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout    <= '0;
            r_clip3 <= 1'b0;
            {hsync_o, vsync_o, csync_o, de_o} <= '0;
        end else if (ce_pix) begin
            dout    <= w_dout3;
            r_clip3 <= w_clip3;
            {hsync_o, vsync_o, csync_o, de_o} <= r_sync2;
        end
    end

`ifdef YPBPR_CLIP_STATS_EN
    // Pixels are counted while they sit on the outputs, evaluated on each advance.
    logic [15:0] r_run;
    logic        r_vs_prev;
    logic        w_count;
    logic        w_edge;

    assign w_count = de_o & r_clip3;
    assign w_edge  = vsync_o & ~r_vs_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_run     <= '0;
            r_vs_prev <= 1'b0;
            clip_cnt  <= '0;
        end else if (ce_pix) begin
            r_vs_prev <= vsync_o;
            if (w_edge) begin
                clip_cnt <= r_run;
                r_run    <= w_count ? 16'd1 : 16'd0;
            end else if (w_count && (r_run != 16'hFFFF)) begin
                r_run <= r_run + 16'd1;
            end
        end
    end
`else
    logic w_unused_clip;
    assign w_unused_clip = r_clip3;
    assign clip_cnt      = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: doc/ypbpr_to_rgb.md
# ypbpr_to_rgb

Pipelined colour-space decoder that converts 8-bit YPbPr (component) pixels back to 8-bit RGB. It is the receive-side counterpart of the video-out encoder: it accepts pixels packed {Pr, Y, Pb} in either limited (16–235/16–240) or full (0–255) range, and returns {R, G, B} with syncs delayed to match. It sits between a component capture/scaler input and the RGB video path. An optional per-frame clip-statistics counter supports calibration.

## Interface
Parameters:
- none; all widths are fixed.

Ports:
- clk  in  1  pixel-domain clock
- reset  in  1  synchronous, active-high reset
- ce_pix  in  1  pixel enable; the pipeline advances only when this is high
- ypbpr_en  in  1  1 = decode din; 0 = bypass din unchanged
- full_range  in  1  1 = full-range coefficients; 0 = limited-range (BT.601 studio)
- din  in  24  [23:16] Pr, [15:8] Y, [7:0] Pb
- hsync, vsync, csync, de  in  1 each  sync and data-enable for the din pixel
- dout  out  24  [23:16] R, [15:8] G, [7:0] B
- hsync_o, vsync_o, csync_o, de_o  out  1 each  delayed sync/de, aligned to dout
- clip_cnt  out  16  clipped-pixel count of the last completed frame

## Operation
- Stage 1 (S1): subtract offsets to form signed 10-bit values.
  - Limited range: Y' = Y−16; Pb' = Pb−128; Pr' = Pr−128.
  - Full range: Y' = Y; Pb' and Pr' are as above.
  - ypbpr_en and full_range are captured per pixel and travel down the pipeline. A mode change therefore applies only to pixels entering S1 after the change.
- Stage 2 (S2): signed products and sums at 21-bit width, coefficients ×256.
  - Limited: R = 298Y' + 409Pr'; G = 298Y' − 100Pb' − 208Pr'; B = 298Y' + 516Pb'.
  - Full: R = 256Y' + 359Pr'; G = 256Y' − 88Pb' − 183Pr'; B = 256Y' + 454Pb'.
- Stage 3 (S3): add 128, arithmetic shift right by 8 (floor), then clamp to 0..255.
  - A channel is flagged "clipped" if its pre-clamp value is <0 or >255.
  - Pixel clip flag = OR of the three channel flags.
- Bypass: when the carried ypbpr_en = 0, dout is din delayed through the same 3 stages, bit-exact. No pixel is flagged clipped.
- Sync alignment: hsync, vsync, csync and de pass through a 3-stage shift register that advances on the same ce_pix as the data.
- Clip counter (see Configuration):
  - A running 16-bit counter increments on each S3 output pixel with de_o=1 and clip flag=1. It saturates at 0xFFFF.
  - On a rising edge of vsync_o, detected on an S3 advance, clip_cnt ← running count.
  - In that same cycle the running count is set to 0, or to 1 if the pixel in that cycle is itself a counted clip.

## Timing
- Latency: 3 ce_pix-qualified cycles from din/syncs to dout/syncs_o.
  - With ce_pix held at 1, this is 3 clk cycles.
- With ce_pix=0, all pipeline registers, outputs and counters hold their values.
- Reset (synchronous, has priority over ce_pix): all pipeline stages, dout, hsync_o, vsync_o, csync_o, de_o, clip_cnt and the running count go to 0 on the next clk edge.
  - The previous vsync_o sample is also cleared to 0, so a vsync_o already high after reset does not count as an edge.
  - Reset asserted mid-frame discards the in-flight pixels. The first valid output appears 3 ce cycles after reset deasserts.
- Simultaneous vsync_o rising edge and counter saturation: the latch captures 0xFFFF, then the running count restarts as described in Operation.
- Input ranges outside the nominal limits (e.g. Y<16 in limited mode) are legal. They are decoded, clamped, and counted as clipped.

## Configuration
- YPBPR_CLIP_STATS_EN defined: the running counter, vsync_o edge detector and clip_cnt latch are built as specified.
- YPBPR_CLIP_STATS_EN undefined: clip_cnt is tied to 16'h0000 and the counter logic is omitted.
- Pixel data and sync behaviour are identical in both builds.

## Test plan
- Limited white: ypbpr_en=1, full_range=0, din=0x80EB80, ce_pix=1 → dout=0xFFFFFF on the 3rd clk; no clip.
- Limited black and clipped red:
  - din=0x801080 → dout=0x000000, no clip.
  - din=0xF01080 → dout=0xB30000 (R=179). G underflows, so the pixel is counted as clipped.
- Full-range grey: full_range=1, din=0x808080 → dout=0x808080.
- Bypass with ce_pix gaps: ypbpr_en=0, din=0x123456, ce_pix toggling 1,0,1,0,1 → dout=0x123456 after exactly 3 high ce cycles. hsync_o, vsync_o, csync_o and de_o follow with identical delay.
- Clip statistics (macro defined): frame of 10 clipped de=1 pixels plus 5 clipped de=0 pixels, then a vsync pulse → clip_cnt=10 at the vsync_o rising edge. The next frame, with none clipped, yields 0.
- Reset mid-stream: assert reset for 1 clk while pixels are in flight → all outputs 0 the next cycle. Valid output resumes 3 ce cycles after deassert. clip_cnt=0.
